// File: rtl/image_page_reader_if.sv
// ----------------------------------------------------------------------------
// image_page_reader_if
//
// Bundles the tile request/status signals, the page RAM read port and the
// pixel stream of image_page_reader into one interface.
//
// Signal groups:
//   request : start, tile_x, tile_y, tile_w, tile_h  (requester -> reader)
//   status  : busy, done, err                        (reader -> requester)
//   ram     : mem_addr, mem_need_data (reader -> RAM), mem_data_in (RAM -> reader)
//   stream  : px_data, px_valid, px_eol, px_last (reader -> sink), px_ready (sink -> reader)
//
// Modports:
//   master : the reader side (drives status, RAM address/enable, stream)
//   slave  : the environment side (requester, page RAM and pixel sink)
// ----------------------------------------------------------------------------
interface image_page_reader_if #(
  parameter int unsigned ADDR_W = 19,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DIM_W  = 10
);

  logic              start;
  logic [DIM_W-1:0]  tile_x;
  logic [DIM_W-1:0]  tile_y;
  logic [DIM_W:0]    tile_w;
  logic [DIM_W:0]    tile_h;

  logic              busy;
  logic              done;
  logic              err;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_need_data;
  logic [DATA_W-1:0] mem_data_in;

  logic [DATA_W-1:0] px_data;
  logic              px_valid;
  logic              px_ready;
  logic              px_eol;
  logic              px_last;

  modport master (
    input  start, tile_x, tile_y, tile_w, tile_h,
    output busy, done, err,
    output mem_addr, mem_need_data,
    input  mem_data_in,
    output px_data, px_valid, px_eol, px_last,
    input  px_ready
  );

  modport slave (
    output start, tile_x, tile_y, tile_w, tile_h,
    input  busy, done, err,
    input  mem_addr, mem_need_data,
    output mem_data_in,
    input  px_data, px_valid, px_eol, px_last,
    output px_ready
  );

endinterface

// File: rtl/image_page_reader.sv
// ----------------------------------------------------------------------------
// image_page_reader
//
// Read-side sequencer for an IMG_W x IMG_H byte-per-pixel image page RAM.
// On an accepted start it walks a rectangular tile in raster order, issues
// one read per pixel into the page RAM (1-cycle registered read data),
// captures the returned data into a 2-entry FIFO and streams the pixels out
// on a valid/ready interface with full backpressure. The RAM is never written.
//
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset (aborts a tile, no done pulse)
//   io   : image_page_reader_if.master
//          start/tile_x/tile_y/tile_w/tile_h : tile request (sampled in IDLE)
//          busy  : high from accepted start until done
//          done  : one-cycle pulse after the px_last handshake
//          err   : one-cycle pulse when a start is rejected
//          mem_addr/mem_need_data : RAM address and read enable
//          mem_data_in            : RAM read data, valid the cycle after a read
//          px_data/px_valid/px_ready/px_eol/px_last : pixel stream
//
// Build option:
//   READER_ZERO_PAD_EN : when defined, tiles crossing the right/bottom image
//   edge are accepted; out-of-image positions produce 0x00 pixels without a
//   RAM read. When undefined such tiles are rejected with err.
// ----------------------------------------------------------------------------
module image_page_reader #(
  parameter int unsigned IMG_W  = 640,
  parameter int unsigned IMG_H  = 640,
  parameter int unsigned ADDR_W = 19,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DIM_W  = 10
) (
  input  logic                clk,
  input  logic                rst,
  image_page_reader_if.master io
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  // Wide enough to hold origin + size without overflow.
  localparam int unsigned EXT_W = DIM_W + 2;

  logic [1:0]        state;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  logic [DIM_W:0]    w_q;
  logic [DIM_W:0]    h_q;
  logic [DIM_W:0]    col;
  logic [DIM_W:0]    row;
  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] addr_q;

  // One read (or pad slot) can be in flight: issued last cycle, lands this cycle.
  logic              inflight;
  logic              inflight_eol;
  logic              inflight_last;

  logic [DATA_W-1:0] fifo_data [2];
  logic              fifo_eol  [2];
  logic              fifo_last [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;

  logic              req_ok;
  logic              issue;
  logic              rd_en;
  logic              col_end;
  logic              row_end;
  logic              pop;
  logic              push;
  logic              head_valid;
  logic [2:0]        occ;
  logic [DATA_W-1:0] push_data;
  logic [ADDR_W-1:0] rd_addr;

  // --------------------------------------------------------------------------
  // Request validation
  // --------------------------------------------------------------------------
`ifdef READER_ZERO_PAD_EN
  assign req_ok = (io.tile_w != '0) && (io.tile_h != '0);
`else
  logic [EXT_W-1:0] x_end;
  logic [EXT_W-1:0] y_end;

  assign x_end  = EXT_W'(io.tile_x) + EXT_W'(io.tile_w);
  assign y_end  = EXT_W'(io.tile_y) + EXT_W'(io.tile_h);
  assign req_ok = (io.tile_w != '0) && (io.tile_h != '0) &&
                  (x_end <= EXT_W'(IMG_W)) && (y_end <= EXT_W'(IMG_H));
`endif

  // --------------------------------------------------------------------------
  // Issue control
  // --------------------------------------------------------------------------
  assign head_valid = (count != 2'd0);
  assign pop        = head_valid & io.px_ready;
  assign push       = inflight;

  // Slots committed after this cycle: buffered + landing - leaving. A new
  // issue is allowed only while that leaves room in the 2-entry FIFO.
  assign occ   = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign issue = (state == S_ISSUE) && (occ < 3'd2);

  assign col_end = (col == (w_q - (DIM_W+1)'(1)));
  assign row_end = (row == (h_q - (DIM_W+1)'(1)));
  assign rd_addr = row_base + ADDR_W'(col);

`ifdef READER_ZERO_PAD_EN
  logic [DIM_W-1:0] x_q;
  logic [DIM_W-1:0] y_q;
  logic             pad_slot;
  logic             pad_q;

  // Out-of-image positions still take a credit slot so raster order and
  // tags stay aligned, but skip the RAM and deliver 0x00.
  assign pad_slot  = ((EXT_W'(x_q) + EXT_W'(col)) >= EXT_W'(IMG_W)) ||
                     ((EXT_W'(y_q) + EXT_W'(row)) >= EXT_W'(IMG_H));
  assign rd_en     = issue & ~pad_slot;
  assign push_data = pad_q ? '0 : io.mem_data_in;
`else
  assign rd_en     = issue;
  assign push_data = io.mem_data_in;
`endif

  assign io.mem_need_data = rd_en;
  assign io.mem_addr      = rd_en ? rd_addr : addr_q;

  // --------------------------------------------------------------------------
  // Output stream and status
  // --------------------------------------------------------------------------
  assign io.px_valid = head_valid;
  assign io.px_data  = head_valid ? fifo_data[rd_ptr] : '0;
  assign io.px_eol   = head_valid & fifo_eol[rd_ptr];
  assign io.px_last  = head_valid & fifo_last[rd_ptr];
  assign io.busy     = busy_q;
  assign io.done     = done_q;
  assign io.err      = err_q;

  // --------------------------------------------------------------------------
  // Sequencer FSM and address walk
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      w_q      <= '0;
      h_q      <= '0;
      col      <= '0;
      row      <= '0;
      row_base <= '0;
      addr_q   <= '0;
`ifdef READER_ZERO_PAD_EN
      x_q      <= '0;
      y_q      <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;

      if (rd_en) begin
        addr_q <= rd_addr;
      end

      case (state)
        S_IDLE: begin
          if (io.start) begin
            if (req_ok) begin
              w_q      <= io.tile_w;
              h_q      <= io.tile_h;
              col      <= '0;
              row      <= '0;
              row_base <= ADDR_W'(io.tile_y) * ADDR_W'(IMG_W) + ADDR_W'(io.tile_x);
`ifdef READER_ZERO_PAD_EN
              x_q      <= io.tile_x;
              y_q      <= io.tile_y;
`endif
              busy_q   <= 1'b1;
              state    <= S_ISSUE;
            end else begin
              err_q    <= 1'b1;
            end
          end
        end

        S_ISSUE: begin
          if (issue) begin
            if (col_end) begin
              col      <= '0;
              row      <= row + (DIM_W+1)'(1);
              row_base <= row_base + ADDR_W'(IMG_W);
              if (row_end) begin
                state <= S_DRAIN;
              end
            end else begin
              col <= col + (DIM_W+1)'(1);
            end
          end
        end

        S_DRAIN: begin
          // The px_last entry is the final one ever pushed, so its handshake
          // implies the FIFO is empty and nothing is in flight.
          if (pop && fifo_last[rd_ptr]) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Read-data capture and 2-entry output FIFO
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight      <= 1'b0;
      inflight_eol  <= 1'b0;
      inflight_last <= 1'b0;
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
      count         <= 2'd0;
      for (int unsigned i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
        fifo_eol[i]  <= 1'b0;
        fifo_last[i] <= 1'b0;
      end
`ifdef READER_ZERO_PAD_EN
      pad_q         <= 1'b0;
`endif
    end else begin
      // Tags are computed at issue time and travel alongside the read.
      inflight      <= issue;
      inflight_eol  <= col_end;
      inflight_last <= col_end & row_end;
`ifdef READER_ZERO_PAD_EN
      pad_q         <= pad_slot;
`endif

      if (push) begin
        fifo_data[wr_ptr] <= push_data;
        fifo_eol[wr_ptr]  <= inflight_eol;
        fifo_last[wr_ptr] <= inflight_last;
        wr_ptr            <= ~wr_ptr;
      end

      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end

      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_image_page_reader.sv
// ----------------------------------------------------------------------------
// tb_image_page_reader
//
// Scoreboard bench for image_page_reader. Stimulus tasks push the expected
// RAM addresses and pixels (data/eol/last) into queues before starting a
// tile; an independent monitor pops and compares on every RAM read and every
// pixel handshake, and also checks stall stability, read credits and the
// done/err pulses. The page RAM model returns addr[7:0] one cycle after a read.
// ----------------------------------------------------------------------------
module tb_image_page_reader;

  localparam int unsigned IMG_W  = 640;
  localparam int unsigned IMG_H  = 640;
  localparam int unsigned ADDR_W = 19;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned DIM_W  = 10;

  typedef struct packed {
    logic [7:0] data;
    logic       eol;
    logic       last;
  } px_t;

  logic clk = 1'b0;
  logic rst;

  int unsigned checks = 0;
  int unsigned errors = 0;

  px_t          exp_px[$];
  logic [18:0]  exp_addr[$];

  int cyc          = 0;
  int issued       = 0;
  int popped       = 0;
  int pix_seen     = 0;
  int done_cnt     = 0;
  int start_cyc    = 0;
  int first_hs_cyc = -1;
  int last_hs_cyc  = 0;
  bit err_ok       = 1'b0;
  int ready_mode   = 0;

  image_page_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DIM_W(DIM_W)) bus ();

  image_page_reader #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .DIM_W (DIM_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io (bus)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Page RAM: registered read returning the low address byte.
  always @(posedge clk) begin
    if (bus.mem_need_data) bus.mem_data_in <= bus.mem_addr[7:0];
  end

  // Downstream ready: constant high, or the 1,0,0,1 stall pattern.
  initial begin
    int ph;
    ph = 0;
    bus.px_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 1) begin
        bus.px_ready = (ph == 0) || (ph == 3);
        ph = (ph + 1) % 4;
      end else begin
        bus.px_ready = 1'b1;
        ph = 0;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // --------------------------------------------------------------------------
  // Monitor / scoreboard
  // --------------------------------------------------------------------------
  initial begin
    bit  prev_stall;
    bit  last_hs_prev;
    px_t prev_head;
    px_t head;
    px_t e;
    prev_stall   = 1'b0;
    last_hs_prev = 1'b0;
    prev_head    = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall   = 1'b0;
        last_hs_prev = 1'b0;
      end else begin
        head = {bus.px_data, bus.px_eol, bus.px_last};

        if (prev_stall) begin
          check("stall_valid", 64'(bus.px_valid), 64'd1);
          check("stall_hold", 64'(head), 64'(prev_head));
        end

        if (bus.px_valid && bus.px_ready) begin
          popped++;
          pix_seen++;
          if (first_hs_cyc < 0) first_hs_cyc = cyc;
          last_hs_cyc = cyc;
          if (exp_px.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pixel_unexpected actual=%0h required=none", head);
          end else begin
            e = exp_px.pop_front();
            check("pixel", 64'(head), 64'(e));
          end
        end

        if (bus.mem_need_data) begin
          issued++;
          if (exp_addr.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL read_unexpected actual=%0d required=none", bus.mem_addr);
          end else begin
            check("read_addr", 64'(bus.mem_addr), 64'(exp_addr.pop_front()));
          end
          check("outstanding_over_2", 64'(issued - popped > 2), 64'd0);
        end

        if (bus.done || last_hs_prev) check("done_pulse", 64'(bus.done), 64'(last_hs_prev));
        if (bus.done) done_cnt++;

        if (bus.err && !err_ok) begin
          checks++;
          errors++;
          $display("FAIL err_unexpected actual=1 required=0");
        end

        last_hs_prev = bus.px_valid && bus.px_ready && bus.px_last;
        prev_stall   = bus.px_valid && !bus.px_ready;
        prev_head    = head;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic build_exp(input int x, input int y, input int w, input int h);
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        int  gx;
        int  gy;
        int  a;
        px_t p;
        gx = x + c;
        gy = y + r;
        a  = gy * int'(IMG_W) + gx;
        p.eol  = (c == w - 1);
        p.last = (c == w - 1) && (r == h - 1);
        if (gx >= int'(IMG_W) || gy >= int'(IMG_H)) begin
          p.data = 8'h00;
        end else begin
          exp_addr.push_back(19'(a));
          p.data = 8'(a);
        end
        exp_px.push_back(p);
      end
    end
  endtask

  task automatic start_tile(input int x, input int y, input int w, input int h);
    bus.tile_x = 10'(x);
    bus.tile_y = 10'(y);
    bus.tile_w = 11'(w);
    bus.tile_h = 11'(h);
    bus.start  = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [63:0] out_vec();
    return 64'({bus.busy, bus.done, bus.err, bus.mem_need_data, bus.px_valid,
                bus.px_eol, bus.px_last, bus.mem_addr, bus.px_data});
  endfunction

  task automatic run_tile(input int x, input int y, input int w, input int h,
                          input bit extra_start, input bit timing);
    int dn0;
    int t;
    build_exp(x, y, w, h);
    dn0 = done_cnt;
    first_hs_cyc = -1;
    start_tile(x, y, w, h);
    check("busy_after_start", 64'(bus.busy), 64'd1);
    if (extra_start) begin
      idle(3);
      check("busy_before_restart", 64'(bus.busy), 64'd1);
      start_tile(0, 0, 2, 2);
    end
    t = 0;
    while (done_cnt == dn0 && t < 3000) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("done_count", 64'(done_cnt), 64'(dn0 + 1));
    check("queues_empty", 64'(exp_px.size() + exp_addr.size()), 64'd0);
    check("busy_after_done", 64'(bus.busy), 64'd0);
    if (timing) begin
      check("first_px_latency", 64'(first_hs_cyc - start_cyc), 64'd2);
      check("burst_span", 64'(last_hs_cyc - first_hs_cyc), 64'(w * h - 1));
    end
    idle(4);
    check("no_stray_done", 64'(done_cnt), 64'(dn0 + 1));
  endtask

  task automatic bad_start(input int x, input int y, input int w, input int h);
    int dn0;
    dn0 = done_cnt;
    err_ok = 1'b1;
    start_tile(x, y, w, h);
    check("err_pulse", 64'(bus.err), 64'd1);
    check("busy_on_reject", 64'(bus.busy), 64'd0);
    idle(1);
    check("err_one_cycle", 64'(bus.err), 64'd0);
    err_ok = 1'b0;
    idle(8);
    check("busy_after_reject", 64'(bus.busy), 64'd0);
    check("no_done_on_reject", 64'(done_cnt), 64'(dn0));
  endtask

  // --------------------------------------------------------------------------
  // Directed sequence
  // --------------------------------------------------------------------------
  initial begin
    int dn0;
    int t;
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.tile_x = '0;
    bus.tile_y = '0;
    bus.tile_w = '0;
    bus.tile_h = '0;
    idle(3);
    check("reset_outputs", out_vec(), 64'd0);
    rst = 1'b0;
    idle(2);

    // Basic tile, full throughput.
    run_tile(3, 2, 4, 2, 1'b0, 1'b1);

    // Same tile under 1,0,0,1 backpressure.
    ready_mode = 1;
    run_tile(3, 2, 4, 2, 1'b0, 1'b0);
    ready_mode = 0;
    idle(2);

    // Tile crossing the right image edge.
`ifdef READER_ZERO_PAD_EN
    run_tile(636, 0, 8, 1, 1'b0, 1'b1);
`else
    bad_start(636, 0, 8, 1);
`endif

    // Zero-sized tile is always rejected.
    bad_start(0, 0, 0, 1);

    // Bottom-right corner pixel.
    run_tile(639, 639, 1, 1, 1'b0, 1'b1);

    // Reset after the 3rd pixel of a 16-pixel tile.
    build_exp(100, 10, 8, 2);
    pix_seen = 0;
    dn0 = done_cnt;
    start_tile(100, 10, 8, 2);
    t = 0;
    while (pix_seen < 3 && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("third_pixel_seen", 64'(pix_seen >= 3), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("outputs_after_rst", out_vec(), 64'd0);
    exp_px.delete();
    exp_addr.delete();
    issued = 0;
    popped = 0;
    idle(6);
    check("no_done_after_rst", 64'(done_cnt), 64'(dn0));
    check("idle_after_rst", 64'(bus.busy), 64'd0);
    run_tile(100, 10, 8, 2, 1'b0, 1'b1);

    // Second start while busy must be ignored.
    run_tile(20, 30, 4, 4, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
